custom_acc_ctrl: RTL and testbench
==================================

Name: custom_acc_ctrl

Overview:
Initiator-side controller for the custom accelerator's start/finish handshake. It is a memory-mapped register block on an Avalon-MM slave port driven by the HPS bridge. Software writes GO; the block issues a single-cycle start pulse and counts cycles until finish arrives. It then latches the cycle count, sets a done flag and optionally raises an interrupt, with a programmable timeout for a hung accelerator.

Parameters:
DEFAULT_TIMEOUT, 64'd100000000, reset value of the 64-bit timeout register; 0 disables the timeout.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
i_avs_address  input  3  word address
i_avs_read  input  1  read strobe
i_avs_write  input  1  write strobe
i_avs_writedata  input  32  write data
o_avs_readdata  output  32  read data, valid exactly 1 cycle after i_avs_read
o_start  output  1  start pulse to accelerator, exactly one cycle wide
i_finish  input  1  one-cycle finish pulse from accelerator
o_irq  output  1  level interrupt = IRQ_EN & (done | timeout)

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM in IDLE, all flags 0, cycle count 0, run count 0, IRQ_EN 0, timeout register = DEFAULT_TIMEOUT. Reset mid-run aborts the run; o_start deasserts immediately.
- Register map (word address):
  - 0 CTRL, write-only. bit0 GO (pulse), bit1 CLR (clears done/timeout/spurious), bit2 IRQ_EN (stored). Reads return {29'b0, IRQ_EN, 2'b0}.
  - 1 STATUS, read-only: bit0 busy, bit1 done, bit2 timeout, bit3 spurious.
  - 2/3 CYCLES_LO/HI, read-only, 64-bit latched count.
  - 4/5 TIMEOUT_LO/HI, R/W.
  - 6 RUNS, read-only, 32-bit count of completed runs, wraps 0xFFFFFFFF->0.
  - 7 reads 0, writes ignored.
- Read latency fixed at 1 cycle; no waitrequest. Simultaneous read and write: the read returns the pre-write value.
- FSM states:
  - IDLE: busy=0. A GO write moves to START. If CLR and GO arrive in the same write, CLR is applied first and the run then starts.
  - START: o_start=1 for this one cycle only; running counter cleared to 0; done and timeout cleared. Next state WAIT.
  - WAIT: busy=1. The running counter increments every cycle, including the cycle where i_finish is sampled high.
    - i_finish=1: CYCLES <= counter+1, done<=1, RUNS+1, go to IDLE.
    - Else, if TIMEOUT!=0 and counter+1 == TIMEOUT: timeout<=1, CYCLES <= TIMEOUT, go to IDLE.
    - If finish and timeout occur in the same cycle, finish wins.
- Resulting latency: with an accelerator configured for N cycles, CYCLES reads N+1, since finish is registered one cycle after the count matches.
- GO while busy: ignored; no flag change.
- i_finish sampled high in IDLE or START: spurious<=1; no other effect (covers a late finish after a timeout).
- CYCLES and RUNS stay stable until the next completion, so 32-bit reads of LO then HI cannot tear.
- TIMEOUT writes during WAIT take effect on the next compare.
- The running counter is 64-bit and saturates at all-ones; it never wraps.

Decomposition:
- Shared package: register address constants, STATUS/CTRL bit indices, FSM state encoding.
- One natural sub-module, acc_ctrl_regs: the Avalon-MM decode and readback mux. The FSM and counters remain in custom_acc_ctrl.

Test Plan:
- Accelerator model with N=10; write CTRL=0x1 -> o_start high exactly 1 cycle, busy=1 until finish. Afterwards STATUS=0x2, CYCLES_LO=11, CYCLES_HI=0, RUNS=1.
- TIMEOUT=5, accelerator model with N=10; GO -> STATUS=0x4 after 5 WAIT cycles and CYCLES_LO=5. The late finish then sets STATUS=0x C (timeout+spurious, value 0xC). A following CTRL=0x2 write gives STATUS=0x0.
- GO written again 3 cycles into a run -> no second o_start pulse; CYCLES_LO=11 and RUNS increments by 1 only.
- IRQ_EN=1 via CTRL=0x4, then GO -> o_irq rises in the cycle after finish is sampled. CTRL=0x6 clears the flags, keeps IRQ_EN and drops o_irq.
- Drive reset low mid-WAIT -> o_start/o_irq go 0 asynchronously, busy=0, TIMEOUT reads back DEFAULT_TIMEOUT; a subsequent GO runs normally.
- Finish and timeout in the same cycle (TIMEOUT=11, N=10) -> done=1, timeout=0, CYCLES_LO=11.

Source files
------------

// File: rtl/custom_acc_ctrl_pkg.sv
// Shared definitions for the accelerator start/finish controller:
// register map, CTRL/STATUS bit positions, FSM encoding and helpers.
package custom_acc_ctrl_pkg;

    // Word addresses on the Avalon-MM slave port
    localparam logic [2:0] AddrCtrl      = 3'd0;
    localparam logic [2:0] AddrStatus    = 3'd1;
    localparam logic [2:0] AddrCyclesLo  = 3'd2;
    localparam logic [2:0] AddrCyclesHi  = 3'd3;
    localparam logic [2:0] AddrTimeoutLo = 3'd4;
    localparam logic [2:0] AddrTimeoutHi = 3'd5;
    localparam logic [2:0] AddrRuns      = 3'd6;

    // CTRL write bits
    localparam int unsigned CtrlGoBit    = 0;
    localparam int unsigned CtrlClrBit   = 1;
    localparam int unsigned CtrlIrqEnBit = 2;

    // STATUS read bits
    localparam int unsigned StatBusyBit     = 0;
    localparam int unsigned StatDoneBit     = 1;
    localparam int unsigned StatTimeoutBit  = 2;
    localparam int unsigned StatSpuriousBit = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2
    } acc_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [63:0] sat_inc64(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/custom_acc_ctrl_if.sv
// Avalon-MM slave bus between the HPS bridge (master) and the controller (slave).
interface custom_acc_ctrl_if;

    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/custom_acc_ctrl_regs.sv
// Avalon-MM decode and readback mux. Holds the software-owned config
// (IRQ_EN, TIMEOUT) and turns CTRL writes into GO/CLR pulses.
module custom_acc_ctrl_regs
    import custom_acc_ctrl_pkg::*;
#(
    parameter logic [63:0] DefaultTimeout = 64'd100000000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    custom_acc_ctrl_if.slave        avs,
    input  logic                    busy_i,
    input  logic                    done_i,
    input  logic                    timeout_i,
    input  logic                    spurious_i,
    input  logic [63:0]             cycles_i,
    input  logic [31:0]             runs_i,
    output logic                    go_o,
    output logic                    clr_o,
    output logic                    irq_en_o,
    output logic [63:0]             timeout_o
);

    logic        irq_en_q, irq_en_d;
    logic [63:0] timeout_q, timeout_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ctrl_wr;

    assign ctrl_wr = avs.avs_write && (avs.avs_address == AddrCtrl);
    assign go_o    = ctrl_wr && avs.avs_writedata[CtrlGoBit];
    assign clr_o   = ctrl_wr && avs.avs_writedata[CtrlClrBit];

    // Config register writes
    always_comb begin
        irq_en_d  = irq_en_q;
        timeout_d = timeout_q;
        if (avs.avs_write) begin
            case (avs.avs_address)
                AddrCtrl:      irq_en_d = avs.avs_writedata[CtrlIrqEnBit];
                AddrTimeoutLo: timeout_d[31:0] = avs.avs_writedata;
                AddrTimeoutHi: timeout_d[63:32] = avs.avs_writedata;
                default:       ;
            endcase
        end
    end

    // Readback mux; sampled from current state so a same-cycle write is not visible
    always_comb begin
        rdata_d = '0;
        if (avs.avs_read) begin
            case (avs.avs_address)
                AddrCtrl:      rdata_d[CtrlIrqEnBit] = irq_en_q;
                AddrStatus: begin
                    rdata_d[StatBusyBit]     = busy_i;
                    rdata_d[StatDoneBit]     = done_i;
                    rdata_d[StatTimeoutBit]  = timeout_i;
                    rdata_d[StatSpuriousBit] = spurious_i;
                end
                AddrCyclesLo:  rdata_d = cycles_i[31:0];
                AddrCyclesHi:  rdata_d = cycles_i[63:32];
                AddrTimeoutLo: rdata_d = timeout_q[31:0];
                AddrTimeoutHi: rdata_d = timeout_q[63:32];
                AddrRuns:      rdata_d = runs_i;
                default:       rdata_d = '0;
            endcase
        end
    end

    // Register state and the one-cycle read data pipeline
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q  <= 1'b0;
            timeout_q <= DefaultTimeout;
            rdata_q   <= '0;
        end else begin
            irq_en_q  <= irq_en_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign irq_en_o         = irq_en_q;
    assign timeout_o        = timeout_q;

endmodule

// File: rtl/custom_acc_ctrl.sv
// Initiator-side controller for the accelerator start/finish handshake:
// issues a one-cycle start, counts cycles to finish, flags done/timeout/spurious.
module custom_acc_ctrl
    import custom_acc_ctrl_pkg::*;
#(
    parameter logic [63:0] DEFAULT_TIMEOUT = 64'd100000000
) (
    input  logic                clk,
    input  logic                reset,
    custom_acc_ctrl_if.slave    avs,
    output logic                o_start,
    input  logic                i_finish,
    output logic                o_irq
);

    acc_state_e  state_q, state_d;
    logic        start_q, start_d;
    logic [63:0] cnt_q, cnt_d;
    logic [63:0] cycles_q, cycles_d;
    logic [31:0] runs_q, runs_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        spurious_q, spurious_d;

    logic        go;
    logic        clr;
    logic        irq_en;
    logic        busy;
    logic [63:0] timeout_val;
    logic [63:0] cnt_inc;

    assign busy    = (state_q != StIdle);
    assign cnt_inc = sat_inc64(cnt_q);

    custom_acc_ctrl_regs #(
        .DefaultTimeout (DEFAULT_TIMEOUT)
    ) u_regs (
        .clk_i      (clk),
        .rst_ni     (reset),
        .avs        (avs),
        .busy_i     (busy),
        .done_i     (done_q),
        .timeout_i  (timeout_q),
        .spurious_i (spurious_q),
        .cycles_i   (cycles_q),
        .runs_i     (runs_q),
        .go_o       (go),
        .clr_o      (clr),
        .irq_en_o   (irq_en),
        .timeout_o  (timeout_val)
    );

    // Next-state: CLR is applied first so CLR+GO in one write clears then starts
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        cnt_d      = cnt_q;
        cycles_d   = cycles_q;
        runs_d     = runs_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        spurious_d = spurious_q;

        if (clr) begin
            done_d     = 1'b0;
            timeout_d  = 1'b0;
            spurious_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (i_finish) spurious_d = 1'b1;
                if (go) begin
                    state_d = StStart;
                    start_d = 1'b1;
                end
            end
            StStart: begin
                if (i_finish) spurious_d = 1'b1;
                cnt_d     = '0;
                done_d    = 1'b0;
                timeout_d = 1'b0;
                state_d   = StWait;
            end
            StWait: begin
                cnt_d = cnt_inc;
                // Finish has priority over a timeout hitting in the same cycle
                if (i_finish) begin
                    cycles_d = cnt_inc;
                    done_d   = 1'b1;
                    runs_d   = runs_q + 32'd1;
                    state_d  = StIdle;
                end else if ((timeout_val != '0) && (cnt_inc == timeout_val)) begin
                    cycles_d  = timeout_val;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, counters and flags; reset aborts any run in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            cnt_q      <= '0;
            cycles_q   <= '0;
            runs_q     <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            cycles_q   <= cycles_d;
            runs_q     <= runs_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            spurious_q <= spurious_d;
        end
    end

    assign o_start = start_q;
    assign o_irq   = irq_en & (done_q | timeout_q);

endmodule

// File: tb/tb_custom_acc_ctrl.sv
// Self-checking bench for custom_acc_ctrl: register table, directed
// multi-cycle sequences and randomized runs against an outcome model.
module tb_custom_acc_ctrl;
    import custom_acc_ctrl_pkg::*;

    localparam logic [63:0] DefTo = 64'd100000000;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic o_start;
    logic o_irq;
    logic i_finish = 1'b0;

    custom_acc_ctrl_if avs_bus();

    custom_acc_ctrl #(
        .DEFAULT_TIMEOUT (DefTo)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (avs_bus),
        .o_start  (o_start),
        .i_finish (i_finish),
        .o_irq    (o_irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Accelerator model: finish pulse lands N+1 cycles after the start cycle
    int acc_n = 10;
    int acc_cnt = 0;
    int start_seen = 0;
    always @(negedge clk) begin
        if (!reset) begin
            acc_cnt  = 0;
            i_finish = 1'b0;
        end else if (o_start) begin
            start_seen++;
            acc_cnt  = acc_n + 1;
            i_finish = 1'b0;
        end else if (acc_cnt > 0) begin
            acc_cnt--;
            i_finish = (acc_cnt == 0);
        end else begin
            i_finish = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_bus.avs_address   = a;
        avs_bus.avs_writedata = d;
        avs_bus.avs_write     = 1'b1;
        @(negedge clk);
        avs_bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_bus.avs_address = a;
        avs_bus.avs_read    = 1'b1;
        @(negedge clk);
        avs_bus.avs_read    = 1'b0;
        d = avs_bus.avs_readdata;
    endtask

    task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    // Poll STATUS until busy drops; returns the last STATUS seen
    task automatic wait_idle(output logic [31:0] st, input string name);
        logic ok;
        ok = 1'b0;
        st = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            bus_read(AddrStatus, st);
            if (!st[StatBusyBit]) ok = 1'b1;
        end
        check({name, "_idle_timeout"}, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] d;
        logic [31:0] st;
        int          s0;
        int          exp_runs;
        logic        found;

        avs_bus.avs_address   = '0;
        avs_bus.avs_read      = 1'b0;
        avs_bus.avs_write     = 1'b0;
        avs_bus.avs_writedata = '0;

        // Reset values, then write/readback through the map
        vecs.push_back('{1'b0, AddrCtrl,      32'h0,        32'h0,        "rst_ctrl"});
        vecs.push_back('{1'b0, AddrStatus,    32'h0,        32'h0,        "rst_status"});
        vecs.push_back('{1'b0, AddrCyclesLo,  32'h0,        32'h0,        "rst_cyc_lo"});
        vecs.push_back('{1'b0, AddrCyclesHi,  32'h0,        32'h0,        "rst_cyc_hi"});
        vecs.push_back('{1'b0, AddrTimeoutLo, 32'h0,        32'h05F5E100, "rst_to_lo"});
        vecs.push_back('{1'b0, AddrTimeoutHi, 32'h0,        32'h0,        "rst_to_hi"});
        vecs.push_back('{1'b0, AddrRuns,      32'h0,        32'h0,        "rst_runs"});
        vecs.push_back('{1'b0, 3'd7,          32'h0,        32'h0,        "rst_addr7"});
        vecs.push_back('{1'b1, AddrTimeoutLo, 32'h00001234, 32'h00001234, "wr_to_lo"});
        vecs.push_back('{1'b1, AddrTimeoutHi, 32'h0000ABCD, 32'h0000ABCD, "wr_to_hi"});
        vecs.push_back('{1'b1, 3'd7,          32'hFFFFFFFF, 32'h0,        "wr_addr7"});
        vecs.push_back('{1'b1, AddrStatus,    32'h0000000F, 32'h0,        "wr_status_ro"});
        vecs.push_back('{1'b1, AddrCyclesLo,  32'h000000FF, 32'h0,        "wr_cyc_ro"});
        vecs.push_back('{1'b1, AddrRuns,      32'h00000005, 32'h0,        "wr_runs_ro"});
        vecs.push_back('{1'b1, AddrCtrl,      32'h00000004, 32'h00000004, "wr_ctrl_irqen"});
        vecs.push_back('{1'b1, AddrCtrl,      32'h00000000, 32'h0,        "wr_ctrl_zero"});
        vecs.push_back('{1'b1, AddrTimeoutLo, 32'h0,        32'h0,        "wr_to_lo0"});
        vecs.push_back('{1'b1, AddrTimeoutHi, 32'h0,        32'h0,        "wr_to_hi0"});

        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        check("rst_o_start", {31'b0, o_start}, 32'd0);
        check("rst_o_irq", {31'b0, o_irq}, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // Simultaneous read and write returns the pre-write value
        @(negedge clk);
        avs_bus.avs_address   = AddrTimeoutLo;
        avs_bus.avs_writedata = 32'h55;
        avs_bus.avs_write     = 1'b1;
        avs_bus.avs_read      = 1'b1;
        @(negedge clk);
        avs_bus.avs_write = 1'b0;
        avs_bus.avs_read  = 1'b0;
        check("rw_same_cycle_old", avs_bus.avs_readdata, 32'h0);
        read_check(AddrTimeoutLo, 32'h55, "rw_same_cycle_new");
        bus_write(AddrTimeoutLo, 32'h0);

        // Basic run, N=10
        acc_n = 10;
        s0 = start_seen;
        bus_write(AddrCtrl, 32'h1);
        read_check(AddrStatus, 32'h1, "basic_busy");
        wait_idle(st, "basic");
        check("basic_start_pulses", start_seen - s0, 1);
        check("basic_status", st, 32'h2);
        read_check(AddrCyclesLo, 32'd11, "basic_cyc_lo");
        read_check(AddrCyclesHi, 32'd0, "basic_cyc_hi");
        read_check(AddrRuns, 32'd1, "basic_runs");

        // Timeout before finish, then the late finish marks spurious
        bus_write(AddrTimeoutLo, 32'd5);
        bus_write(AddrCtrl, 32'h1);
        wait_idle(st, "to");
        check("to_status", st, 32'h4);
        read_check(AddrCyclesLo, 32'd5, "to_cyc_lo");
        repeat (12) @(negedge clk);
        read_check(AddrStatus, 32'hC, "to_spurious");
        bus_write(AddrCtrl, 32'h2);
        read_check(AddrStatus, 32'h0, "to_clr");
        read_check(AddrRuns, 32'd1, "to_runs");

        // GO while busy is ignored
        bus_write(AddrTimeoutLo, 32'd0);
        s0 = start_seen;
        bus_write(AddrCtrl, 32'h1);
        repeat (3) @(negedge clk);
        bus_write(AddrCtrl, 32'h1);
        wait_idle(st, "gobusy");
        check("gobusy_start_pulses", start_seen - s0, 1);
        check("gobusy_status", st, 32'h2);
        read_check(AddrCyclesLo, 32'd11, "gobusy_cyc_lo");
        read_check(AddrRuns, 32'd2, "gobusy_runs");

        // Interrupt timing and clear
        bus_write(AddrCtrl, 32'h2);
        bus_write(AddrCtrl, 32'h4);
        check("irq_pre", {31'b0, o_irq}, 32'd0);
        bus_write(AddrCtrl, 32'h5);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (i_finish) begin
                found = 1'b1;
                check("irq_low_at_finish", {31'b0, o_irq}, 32'd0);
                @(posedge clk);
                #1;
                check("irq_rise", {31'b0, o_irq}, 32'd1);
            end
        end
        check("irq_finish_seen", {31'b0, found}, 32'd1);
        wait_idle(st, "irq");
        bus_write(AddrCtrl, 32'h6);
        check("irq_cleared", {31'b0, o_irq}, 32'd0);
        read_check(AddrCtrl, 32'h4, "irq_en_kept");
        read_check(AddrStatus, 32'h0, "irq_status_clr");

        // Finish and timeout in the same cycle: finish wins
        bus_write(AddrTimeoutLo, 32'd11);
        bus_write(AddrCtrl, 32'h1);
        wait_idle(st, "tie");
        check("tie_status", st, 32'h2);
        read_check(AddrCyclesLo, 32'd11, "tie_cyc_lo");
        read_check(AddrRuns, 32'd4, "tie_runs");

        // Asynchronous reset while the start pulse is high
        bus_write(AddrCtrl, 32'h1);
        #2;
        check("arst_start_before", {31'b0, o_start}, 32'd1);
        reset = 1'b0;
        #1;
        check("arst_start_low", {31'b0, o_start}, 32'd0);
        check("arst_irq_low", {31'b0, o_irq}, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        read_check(AddrStatus, 32'h0, "arst_status");
        read_check(AddrTimeoutLo, DefTo[31:0], "arst_to_lo");
        read_check(AddrTimeoutHi, DefTo[63:32], "arst_to_hi");
        read_check(AddrRuns, 32'd0, "arst_runs");
        s0 = start_seen;
        bus_write(AddrCtrl, 32'h1);
        wait_idle(st, "arst_run");
        check("arst_run_status", st, 32'h2);
        check("arst_run_pulses", start_seen - s0, 1);
        read_check(AddrCyclesLo, 32'd11, "arst_run_cyc");
        read_check(AddrRuns, 32'd1, "arst_run_runs");
        exp_runs = 1;

        // Randomized runs: outcome decided only by N and TIMEOUT
        for (int r = 0; r < 12; r++) begin
            int          n;
            logic [31:0] t;
            logic        ie;
            logic [31:0] exp_st;
            logic [31:0] exp_cyc;
            n = $urandom_range(1, 20);
            case ($urandom_range(0, 2))
                0:       t = 32'd0;
                1:       t = n + 1;
                default: t = $urandom_range(1, 25);
            endcase
            ie = 1'($urandom_range(0, 1));
            if (t != 0 && t < n + 1) begin
                exp_st  = 32'hC;
                exp_cyc = t;
            end else begin
                exp_st  = 32'h2;
                exp_cyc = n + 1;
                exp_runs++;
            end
            acc_n = n;
            bus_write(AddrTimeoutLo, t);
            bus_write(AddrTimeoutHi, 32'd0);
            s0 = start_seen;
            bus_write(AddrCtrl, {29'b0, ie, 2'b11});
            wait_idle(st, "rnd");
            repeat (n + 4) @(negedge clk);
            check("rnd_pulses", start_seen - s0, 1);
            read_check(AddrStatus, exp_st, "rnd_status");
            read_check(AddrCyclesLo, exp_cyc, "rnd_cyc_lo");
            read_check(AddrCyclesHi, 32'd0, "rnd_cyc_hi");
            read_check(AddrRuns, exp_runs, "rnd_runs");
            check("rnd_irq", {31'b0, o_irq}, {31'b0, ie});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
